// File: rtl/om_reader.sv
// Read-side controller for the output memory: drains every OM word in address
// order onto a valid/ready stream once the full flag is seen, then hands the OM back.
module om_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 784
) (
    input  logic                  OM_READER_Clk,
    input  logic                  OM_READER_Reset,
    input  logic                  OM_READER_Flag_Om_Full,
    output logic                  OM_READER_Rd_En,
    output logic [ADDR_WIDTH-1:0] OM_READER_Rd_Addr,
    input  logic [DATA_WIDTH-1:0] OM_READER_Rd_Data,
    output logic [DATA_WIDTH-1:0] OM_READER_Out_Data,
    output logic                  OM_READER_Out_Valid,
    input  logic                  OM_READER_Out_Ready,
    output logic                  OM_READER_Out_Last,
    output logic                  OM_READER_Om_Full_Clr,
    output logic                  OM_READER_Rptclr,
    output logic                  OM_READER_Busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        PRESENT,
        CLEAR,
        WAIT_LOW
    } state_t;

    state_t                  state_q, state_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    clr_q, clr_d;
    logic                    busy_q, busy_d;

    // Next state; Rd_Addr doubles as the drain pointer
    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;

        case (state_q)
            IDLE: begin
                if (OM_READER_Flag_Om_Full) begin
                    state_d   = RD_ADDR;
                    rd_addr_d = '0;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                out_data_d = OM_READER_Rd_Data;
                out_last_d = (rd_addr_q == LAST_ADDR);
                state_d    = PRESENT;
            end
            PRESENT: begin
                if (out_valid_q && OM_READER_Out_Ready) begin
                    out_last_d = 1'b0;
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d   = CLEAR;
                        rd_addr_d = '0;
                    end else begin
                        state_d   = RD_ADDR;
                        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            CLEAR: state_d = WAIT_LOW;
            // Hold off until the writer drops the stale flag
            WAIT_LOW: begin
                if (!OM_READER_Flag_Om_Full) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_en_d     = (state_d == RD_ADDR);
        out_valid_d = (state_d == PRESENT);
        clr_d       = (state_d == CLEAR);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge OM_READER_Clk or posedge OM_READER_Reset) begin
        if (OM_READER_Reset) begin
            state_q     <= IDLE;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            clr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            clr_q       <= clr_d;
            busy_q      <= busy_d;
        end
    end

    assign OM_READER_Rd_En         = rd_en_q;
    assign OM_READER_Rd_Addr       = rd_addr_q;
    assign OM_READER_Out_Data      = out_data_q;
    assign OM_READER_Out_Valid     = out_valid_q;
    assign OM_READER_Out_Last      = out_last_q;
    assign OM_READER_Om_Full_Clr   = clr_q;
    assign OM_READER_Rptclr        = clr_q;
    assign OM_READER_Busy          = busy_q;

endmodule

// File: tb/tb_om_reader.sv
// Bench for om_reader: a DEPTH=4 instance (full address range) and a DEPTH=1
// instance, checked against the expected in-order word stream of the OM contents.
module tb_om_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=4 instance, ADDR_WIDTH=2 so the last address is all-ones
    logic       flag4, rd_en4, ready4, valid4, last4, fclr4, rptclr4, busy4;
    logic [1:0] rd_addr4;
    logic [7:0] rd_data4, data4;
    logic [7:0] mem4 [4];

    om_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_dut4 (
        .OM_READER_Clk         (clk),
        .OM_READER_Reset       (rst),
        .OM_READER_Flag_Om_Full(flag4),
        .OM_READER_Rd_En       (rd_en4),
        .OM_READER_Rd_Addr     (rd_addr4),
        .OM_READER_Rd_Data     (rd_data4),
        .OM_READER_Out_Data    (data4),
        .OM_READER_Out_Valid   (valid4),
        .OM_READER_Out_Ready   (ready4),
        .OM_READER_Out_Last    (last4),
        .OM_READER_Om_Full_Clr (fclr4),
        .OM_READER_Rptclr      (rptclr4),
        .OM_READER_Busy        (busy4)
    );

    // DEPTH=1 instance
    logic       flag1, rd_en1, ready1, valid1, last1, fclr1, rptclr1, busy1;
    logic [3:0] rd_addr1;
    logic [7:0] rd_data1, data1;
    logic [7:0] mem1;

    om_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(1)) u_dut1 (
        .OM_READER_Clk         (clk),
        .OM_READER_Reset       (rst),
        .OM_READER_Flag_Om_Full(flag1),
        .OM_READER_Rd_En       (rd_en1),
        .OM_READER_Rd_Addr     (rd_addr1),
        .OM_READER_Rd_Data     (rd_data1),
        .OM_READER_Out_Data    (data1),
        .OM_READER_Out_Valid   (valid1),
        .OM_READER_Out_Ready   (ready1),
        .OM_READER_Out_Last    (last1),
        .OM_READER_Om_Full_Clr (fclr1),
        .OM_READER_Rptclr      (rptclr1),
        .OM_READER_Busy        (busy1)
    );

    // Synchronous-read OM models
    always @(posedge clk) if (rd_en4) rd_data4 <= mem4[rd_addr4];
    always @(posedge clk) if (rd_en1) rd_data1 <= mem1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Observation state for the DEPTH=4 instance
    logic [8:0] got_q[$];
    int         hs_q[$];
    int         cyc = 0;
    int         clr_cnt, clr_cyc, first_valid, flag_cyc;
    int         rdy_mode, stall_left;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    // One cycle: sample at negedge, choose Ready for the coming edge, record handshakes
    task automatic tick();
        @(negedge clk);
        cyc++;
        case (rdy_mode)
            0: ready4 = 1'b1;
            1: ready4 = 1'($urandom_range(0, 1));
            2: begin
                if (valid4 && got_q.size() == 1 && stall_left > 0) begin
                    ready4 = 1'b0;
                    stall_left--;
                end else begin
                    ready4 = 1'b1;
                end
            end
            default: ready4 = (got_q.size() == 0);
        endcase
        if (prev_stall) begin
            check("stall_valid", 32'(valid4), 32'd1);
            check("stall_data", 32'(data4), 32'(prev_data));
            check("stall_last", 32'(last4), 32'(prev_last));
        end
        if (valid4) check("rd_en_while_valid", 32'(rd_en4), 32'd0);
        if (rd_en4) check("rd_addr_order", 32'(rd_addr4), 32'(got_q.size()));
        if (fclr4 || rptclr4) check("clr_pair", 32'(rptclr4), 32'(fclr4));
        if (fclr4) begin
            clr_cnt++;
            clr_cyc = cyc;
        end
        if (valid4 && first_valid < 0) first_valid = cyc;
        if (valid4 && ready4) begin
            got_q.push_back({last4, data4});
            hs_q.push_back(cyc);
        end
        prev_stall = valid4 && !ready4;
        prev_data  = data4;
        prev_last  = last4;
    endtask

    // Fill the OM, raise the flag and compare the drained stream with the OM contents
    task automatic run_drain(input int m, input bit drop);
        for (int i = 0; i < 4; i++) mem4[i] = 8'($urandom);
        got_q.delete();
        hs_q.delete();
        clr_cnt     = 0;
        first_valid = -1;
        rdy_mode    = m;
        stall_left  = 5;
        flag4       = 1'b1;
        flag_cyc    = cyc;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (drop && got_q.size() >= 1) flag4 = 1'b0;
            if (clr_cnt > 0) break;
        end
        repeat (4) tick();
        check("clr_count", 32'(clr_cnt), 32'd1);
        check("word_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check("word", 32'(got_q[i]), 32'({(i == 3), mem4[i]}));
            check("clr_after_last", 32'(clr_cyc - hs_q[3]), 32'd1);
            if (m == 0) begin
                check("first_latency", 32'(first_valid - flag_cyc), 32'd3);
                for (int i = 1; i < 4; i++)
                    check("word_spacing", 32'(hs_q[i] - hs_q[i-1]), 32'd3);
            end
        end
        if (m == 2) check("stall_applied", 32'(stall_left), 32'd0);
    endtask

    task automatic release_flag();
        flag4 = 1'b0;
        tick();
        tick();
        check("idle_busy", 32'(busy4), 32'd0);
    endtask

    initial begin
        flag4    = 1'b0;
        flag1    = 1'b0;
        ready4   = 1'b0;
        ready1   = 1'b1;
        rdy_mode = 0;
        #1;
        check("rst_outputs4", 32'({rd_en4, valid4, last4, fclr4, rptclr4, busy4}), 32'd0);
        check("rst_addr4", 32'(rd_addr4), 32'd0);
        check("rst_data4", 32'(data4), 32'd0);
        check("rst_outputs1", 32'({rd_en1, valid1, last1, fclr1, rptclr1, busy1, data1}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();

        // Ready held high, then flag held high after the clear
        run_drain(0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("wait_low_busy", 32'(busy4), 32'd1);
            check("wait_low_rd_en", 32'(rd_en4), 32'd0);
        end
        release_flag();

        // Five-cycle stall on the second word, then a drop of the flag mid-drain
        run_drain(2, 1'b0);
        release_flag();
        run_drain(0, 1'b1);
        check("drop_idle", 32'(busy4), 32'd0);

        repeat (3) begin
            run_drain(1, 1'b0);
            release_flag();
        end

        // Reset while the second word is being presented
        got_q.delete();
        clr_cnt  = 0;
        rdy_mode = 3;
        flag4    = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (valid4 && got_q.size() == 1) break;
        end
        check("reached_word2", 32'(valid4), 32'd1);
        rst = 1'b1;
        #1;
        prev_stall = 1'b0;
        check("async_rst_outputs", 32'({rd_en4, valid4, last4, fclr4, rptclr4, busy4}), 32'd0);
        check("async_rst_addr", 32'(rd_addr4), 32'd0);
        check("async_rst_data", 32'(data4), 32'd0);
        repeat (3) tick();
        check("rst_no_clear", 32'(clr_cnt), 32'd0);
        rst = 1'b0;
        run_drain(0, 1'b0);
        release_flag();

        // DEPTH=1: single word with Last, then the clear pulse
        begin
            int         n_words = 0, n_clr = 0, hs_cyc = -1, clr1_cyc = -1, v_cyc = -1;
            logic [7:0] w = 8'h00;
            logic       l = 1'b0;
            mem1  = 8'hA5;
            flag1 = 1'b1;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                if (rd_en1) check("d1_rd_addr", 32'(rd_addr1), 32'd0);
                if (valid1 && v_cyc < 0) v_cyc = c;
                if (valid1 && ready1) begin
                    n_words++;
                    w      = data1;
                    l      = last1;
                    hs_cyc = c;
                end
                if (fclr1) begin
                    n_clr++;
                    clr1_cyc = c;
                    check("d1_rptclr", 32'(rptclr1), 32'd1);
                end
            end
            check("d1_words", 32'(n_words), 32'd1);
            check("d1_data", 32'(w), 32'hA5);
            check("d1_last", 32'(l), 32'd1);
            check("d1_latency", 32'(v_cyc), 32'd3);
            check("d1_clr_count", 32'(n_clr), 32'd1);
            check("d1_clr_timing", 32'(clr1_cyc - hs_cyc), 32'd1);
            check("d1_wait_low", 32'(busy1), 32'd1);
            flag1 = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/om_reader.md
Name: om_reader

Overview:
- Read-side controller for the output memory (OM); the write-side set-enable/clear logic fills it.
- When the OM full flag asserts, the block reads every OM word in address order.
- Each word is presented on a valid/ready stream to the NIOS-facing interface.
- After the last word it pulses a full-flag clear and a read-pointer clear, handing the OM back to the writer.

Parameters:
- DATA_WIDTH, 8, OM word width.
- ADDR_WIDTH, 10, OM address width.
- DEPTH, 784, words per drain; legal range 1 to 2^ADDR_WIDTH.

Ports:
- OM_READER_Clk  in  1  clock; all logic on rising edge.
- OM_READER_Reset  in  1  asynchronous, active-high reset.
- OM_READER_Flag_Om_Full  in  1  OM full flag from the write side.
- OM_READER_Rd_En  out  1  OM synchronous read enable.
- OM_READER_Rd_Addr  out  ADDR_WIDTH  OM read address.
- OM_READER_Rd_Data  in  DATA_WIDTH  OM read data, valid 1 cycle after Rd_En.
- OM_READER_Out_Data  out  DATA_WIDTH  stream data.
- OM_READER_Out_Valid  out  1  stream valid.
- OM_READER_Out_Ready  in  1  stream ready from the consumer.
- OM_READER_Out_Last  out  1  high with the word at address DEPTH-1.
- OM_READER_Om_Full_Clr  out  1  one-cycle pulse clearing the full flag.
- OM_READER_Rptclr  out  1  one-cycle pulse, read pointer cleared (same cycle as Om_Full_Clr).
- OM_READER_Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, any state):
  - state=IDLE, Rd_Addr=0, all other outputs 0 (Rd_En, Out_Valid, Out_Last, Om_Full_Clr, Rptclr, Busy, Out_Data).
  - Reset mid-drain aborts immediately; no clear pulse is issued.
- States: IDLE, RD_ADDR, RD_DATA, PRESENT, CLEAR, WAIT_LOW.
- IDLE: Flag_Om_Full=1 sampled -> RD_ADDR with Rd_Addr=0.
- RD_ADDR:
  - Rd_En=1 for exactly this one cycle, Rd_Addr = current pointer.
  - -> RD_DATA.
- RD_DATA:
  - Rd_Data registered into Out_Data at the end of this cycle.
  - Out_Valid=1 from the next cycle.
  - Out_Last=1 if pointer==DEPTH-1.
  - -> PRESENT.
- PRESENT:
  - Out_Valid held at 1; Out_Data and Out_Last held stable until Out_Valid & Out_Ready.
  - On handshake: Out_Valid drops next cycle.
  - If pointer==DEPTH-1 -> CLEAR; else pointer+1 and -> RD_ADDR.
- Throughput and latency:
  - With Ready held high, one word every 3 cycles.
  - First Out_Valid appears 3 cycles after the cycle in which Flag_Om_Full is sampled high in IDLE.
- CLEAR:
  - Om_Full_Clr=1 and Rptclr=1 for exactly one cycle; pointer reset to 0.
  - -> WAIT_LOW.
- WAIT_LOW:
  - Stay until Flag_Om_Full=0, then -> IDLE.
  - Prevents a second drain from the same stale flag.
- Flag_Om_Full deasserting mid-drain is ignored; the drain always completes all DEPTH words.
- Out_Ready high while Out_Valid=0 has no effect.
- Pointer arithmetic:
  - Unsigned ADDR_WIDTH, never exceeds DEPTH-1, no wrap.
  - DEPTH=2^ADDR_WIDTH is legal; the last address is all-ones.
- DEPTH=1: the first word carries Out_Last=1, then CLEAR.
- Rd_Addr changes only on the transition into RD_ADDR or CLEAR.

Test Plan:
- DEPTH=4, OM={0x11,0x22,0x33,0x44}, Ready=1, flag raised -> Out_Data 0x11,0x22,0x33,0x44 on cycles 3,6,9,12 after sampling. Out_Last only with 0x44. One Om_Full_Clr/Rptclr pulse the cycle after the 0x44 handshake.
- Same setup, Ready low for 5 cycles during 0x22 -> Out_Data=0x22 and Out_Valid stay stable for all 5 cycles. No Rd_En during the stall. Output order unchanged.
- Flag dropped after the first word -> all 4 words still delivered, then exactly one clear pulse, then IDLE.
- Flag held high after CLEAR -> remains in WAIT_LOW with Busy=1 and no Rd_En. Flag low then high again -> second full drain starting at address 0.
- Reset asserted during PRESENT of word 2 -> all outputs 0 asynchronously, no clear pulse. After release with flag high -> drain restarts at address 0.
- DEPTH=1, OM[0]=0xA5 -> a single word 0xA5 with Out_Last=1, then the clear pulse.
